apb_rr_master_ctrl: RTL and testbench

- Two-requester APB master controller. Shares one APB bus between requester 0 and requester 1 using round-robin arbitration.
- Sequences each accepted request through the APB SETUP and ACCESS phases, honours PREADY wait states, and returns read data and PSLVERR to the originating requester.
- Drives the two-slave APB segment: PADDR[8] selects slave 1 (0) or slave 2 (1).

---
 rtl/apb_rr_master_ctrl.sv | 174 +++++++++++++++++
 tb/tb_apb_rr_master_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_rr_master_ctrl.sv
// apb_rr_master_ctrl: two-requester round-robin APB master with registered SETUP/ACCESS sequencing.
// Defining APB_TIMEOUT_EN adds an ACCESS wait-state timeout of TIMEOUT_CYCLES.
module apb_rr_master_ctrl #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic              PSEL1,
    output logic              PSEL2,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA1,
    input  logic [DATA_W-1:0] PRDATA2,
    input  logic              PREADY,
    input  logic              PSLVERR
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    state_t state_q, state_d;
    logic last_grant_q, last_grant_d, owner_q, owner_d;
    logic psel1_q, psel1_d, psel2_q, psel2_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic req0_ready_q, req0_ready_d, req1_ready_q, req1_ready_d;
    logic rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
    logic rsp0_err_q, rsp0_err_d, rsp1_err_q, rsp1_err_d;
    logic [DATA_W-1:0] rsp0_rdata_q, rsp0_rdata_d, rsp1_rdata_q, rsp1_rdata_d;
    logic done, timed_out, arb, pick;
    logic [DATA_W-1:0] rdata;
`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    assign timed_out = (state_q == ACCESS) && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES));
    assign wait_cnt_d = (state_q == SETUP) ? '0 :
                        (state_q == ACCESS && !PREADY && !timed_out) ? wait_cnt_q + 1'b1 : wait_cnt_q;
    always_ff @(posedge PCLK) begin
        if (PRESET) wait_cnt_q <= '0;
        else wait_cnt_q <= wait_cnt_d;
    end
`else
    assign timed_out = TIMEOUT_CYCLES < 0;
`endif
    assign done = (state_q == ACCESS) && (PREADY || timed_out);
    assign arb = (state_q == IDLE) || done;
    // on a tie the requester that did not win last time gets the bus
    assign pick = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    assign rdata = timed_out ? '0 : (paddr_q[ADDR_W-1] ? PRDATA2 : PRDATA1);

    always_comb begin
        state_d = state_q;
        last_grant_d = last_grant_q;
        owner_d = owner_q;
        psel1_d = psel1_q;
        psel2_d = psel2_q;
        penable_d = penable_q;
        pwrite_d = pwrite_q;
        paddr_d = paddr_q;
        pwdata_d = pwdata_q;
        req0_ready_d = 1'b0;
        req1_ready_d = 1'b0;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp0_rdata_d = rsp0_rdata_q;
        rsp1_rdata_d = rsp1_rdata_q;
        rsp0_err_d = rsp0_err_q;
        rsp1_err_d = rsp1_err_q;
        if (state_q == SETUP) begin
            state_d = ACCESS;
            penable_d = 1'b1;
        end
        if (done) begin
            rsp0_valid_d = ~owner_q;
            rsp1_valid_d = owner_q;
            rsp0_rdata_d = owner_q ? rsp0_rdata_q : rdata;
            rsp1_rdata_d = owner_q ? rdata : rsp1_rdata_q;
            rsp0_err_d = owner_q ? rsp0_err_q : (PSLVERR || timed_out);
            rsp1_err_d = owner_q ? (PSLVERR || timed_out) : rsp1_err_q;
        end
        if (arb) begin
            if (req0_valid || req1_valid) begin
                state_d = SETUP;
                owner_d = pick;
                last_grant_d = pick;
                req0_ready_d = ~pick;
                req1_ready_d = pick;
                pwrite_d = pick ? req1_write : req0_write;
                paddr_d = pick ? req1_addr : req0_addr;
                pwdata_d = pick ? req1_wdata : req0_wdata;
                psel1_d = ~paddr_d[ADDR_W-1];
                psel2_d = paddr_d[ADDR_W-1];
                penable_d = 1'b0;
            end else begin
                state_d = IDLE;
                psel1_d = 1'b0;
                psel2_d = 1'b0;
                penable_d = 1'b0;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
            last_grant_q <= 1'b1;
            owner_q <= 1'b0;
            psel1_q <= 1'b0;
            psel2_q <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q <= 1'b0;
            paddr_q <= '0;
            pwdata_q <= '0;
            req0_ready_q <= 1'b0;
            req1_ready_q <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
            rsp0_err_q <= 1'b0;
            rsp1_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_grant_q <= last_grant_d;
            owner_q <= owner_d;
            psel1_q <= psel1_d;
            psel2_q <= psel2_d;
            penable_q <= penable_d;
            pwrite_q <= pwrite_d;
            paddr_q <= paddr_d;
            pwdata_q <= pwdata_d;
            req0_ready_q <= req0_ready_d;
            req1_ready_q <= req1_ready_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
            rsp0_err_q <= rsp0_err_d;
            rsp1_err_q <= rsp1_err_d;
        end
    end

    assign req0_ready = req0_ready_q;
    assign req1_ready = req1_ready_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_rdata = rsp1_rdata_q;
    assign rsp0_err = rsp0_err_q;
    assign rsp1_err = rsp1_err_q;
    assign PSEL1 = psel1_q;
    assign PSEL2 = psel2_q;
    assign PENABLE = penable_q;
    assign PWRITE = pwrite_q;
    assign PADDR = paddr_q;
    assign PWDATA = pwdata_q;
endmodule

// File: tb/tb_apb_rr_master_ctrl.sv
// tb_apb_rr_master_ctrl: directed scoreboard bench; grant, bus and response monitors pop expected queues.
module tb_apb_rr_master_ctrl;
    logic PCLK = 0, PRESET;
    logic req0_valid, req0_write, req1_valid, req1_write;
    logic [8:0] req0_addr, req1_addr, PADDR;
    logic [7:0] req0_wdata, req1_wdata, rsp0_rdata, rsp1_rdata, PWDATA, PRDATA1, PRDATA2;
    logic req0_ready, rsp0_valid, rsp0_err, req1_ready, rsp1_valid, rsp1_err;
    logic PSEL1, PSEL2, PENABLE, PWRITE, PREADY, PSLVERR;

    typedef struct {int who; bit chk; logic [7:0] rdata; bit err;} rsp_t;
    typedef struct {bit s1; bit s2; bit w; logic [8:0] a; logic [7:0] d; int len; int gap;} bus_t;
    rsp_t rsp_q[$];
    bus_t bus_q[$];
    int grant_q[$];
    int checks = 0, fails = 0;
    int waits_cfg = 0, k = 0, idle = 0, psel_cyc = 0, acc_cyc = 0;
    bit err_cfg = 0;

    apb_rr_master_ctrl dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {req0_ready, rsp0_valid, rsp0_rdata, rsp0_err, req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
                PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA};
    endfunction

    // slave model: PREADY rises on ACCESS cycle waits_cfg+1
    always @(posedge PCLK) begin
        #1;
        if ((PSEL1 || PSEL2) && !PENABLE) k = 0;
        else if (PENABLE) k++;
        PREADY = (k > waits_cfg);
        PSLVERR = err_cfg && PREADY;
    end

    always @(negedge PCLK) begin
        if (req0_ready || req1_ready) begin
            if (grant_q.size() == 0) begin
                checks++; fails++;
                $display("FAIL grant: unexpected ready r0=%0b r1=%0b", req0_ready, req1_ready);
            end else begin
                int g;
                g = grant_q.pop_front();
                chk("grant", {req0_ready, req1_ready}, (g == 0) ? 2'b10 : 2'b01);
            end
        end
    end

    always @(negedge PCLK) begin
        if (rsp0_valid || rsp1_valid) begin
            if (rsp_q.size() == 0) begin
                checks++; fails++;
                $display("FAIL rsp: unexpected response v0=%0b v1=%0b", rsp0_valid, rsp1_valid);
            end else begin
                rsp_t e;
                e = rsp_q.pop_front();
                chk("rsp_who", {rsp0_valid, rsp1_valid}, (e.who == 0) ? 2'b10 : 2'b01);
                chk("rsp_err", rsp0_valid ? rsp0_err : rsp1_err, e.err);
                if (e.chk) chk("rsp_rdata", rsp0_valid ? rsp0_rdata : rsp1_rdata, e.rdata);
            end
        end
    end

    always @(negedge PCLK) begin
        if (PSEL1 || PSEL2) begin
            psel_cyc++;
            if (PENABLE) acc_cyc++;
            if (PENABLE && PREADY) begin
                if (bus_q.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL bus: unexpected completion addr=%0h", PADDR);
                end else begin
                    bus_t e;
                    e = bus_q.pop_front();
                    chk("bus_fields", {PSEL1, PSEL2, PWRITE, PADDR, PWDATA}, {e.s1, e.s2, e.w, e.a, e.d});
                    chk("access_len", acc_cyc, e.len);
                    chk("setup_len", psel_cyc, acc_cyc + 1);
                    if (e.gap >= 0) chk("idle_gap", idle, e.gap);
                end
                psel_cyc = 0;
                acc_cyc = 0;
                idle = 0;
            end
        end else begin
            idle++;
            psel_cyc = 0;
            acc_cyc = 0;
        end
    end

    task automatic issue(input int n, input bit w, input logic [8:0] a, input logic [7:0] d);
        int t = 0;
        if (n == 0) begin req0_write = w; req0_addr = a; req0_wdata = d; req0_valid = 1; end
        else begin req1_write = w; req1_addr = a; req1_wdata = d; req1_valid = 1; end
        do begin @(negedge PCLK); t++; end while (!(n == 0 ? req0_ready : req1_ready) && t < 200);
        if (t >= 200) begin
            checks++; fails++;
            $display("FAIL ready_timeout: req%0d got no ready, required one", n);
        end
        if (n == 0) req0_valid = 0; else req1_valid = 0;
    endtask

    task automatic settle();
        for (int t = 0; t < 300 && (rsp_q.size() || bus_q.size() || grant_q.size()); t++) @(negedge PCLK);
        repeat (3) @(negedge PCLK);
    endtask

    initial begin
        PRESET = 1;
        {req0_valid, req0_write, req0_addr, req0_wdata} = '0;
        {req1_valid, req1_write, req1_addr, req1_wdata} = '0;
        PRDATA1 = 8'h11; PRDATA2 = 8'h33; PREADY = 0; PSLVERR = 0;
        repeat (2) @(negedge PCLK);
        chk("reset_outputs", all_outs(), 0);
        PRESET = 0;
        @(negedge PCLK);
        // single write to slave 1, no waits
        grant_q.push_back(0);
        bus_q.push_back('{1, 0, 1, 9'h005, 8'h0A, 1, -1});
        rsp_q.push_back('{0, 0, 8'h00, 0});
        issue(0, 1, 9'h005, 8'h0A);
        settle();
        // read slave 2 with three wait states
        waits_cfg = 3;
        grant_q.push_back(1);
        bus_q.push_back('{0, 1, 0, 9'h103, 8'h00, 4, -1});
        rsp_q.push_back('{1, 1, 8'h33, 0});
        issue(1, 0, 9'h103, 8'h00);
        settle();
        // both requesters saturating: strict alternation, back-to-back
        waits_cfg = 0; PRDATA1 = 8'h44; PRDATA2 = 8'h55;
        grant_q.push_back(0); grant_q.push_back(1); grant_q.push_back(0); grant_q.push_back(1);
        bus_q.push_back('{1, 0, 1, 9'h010, 8'hA1, 1, -1});
        bus_q.push_back('{0, 1, 0, 9'h120, 8'h00, 1, 0});
        bus_q.push_back('{1, 0, 0, 9'h020, 8'h00, 1, 0});
        bus_q.push_back('{0, 1, 1, 9'h1FF, 8'hB2, 1, 0});
        rsp_q.push_back('{0, 0, 8'h00, 0});
        rsp_q.push_back('{1, 1, 8'h55, 0});
        rsp_q.push_back('{0, 1, 8'h44, 0});
        rsp_q.push_back('{1, 0, 8'h00, 0});
        fork
            begin issue(0, 1, 9'h010, 8'hA1); issue(0, 0, 9'h020, 8'h00); end
            begin issue(1, 0, 9'h120, 8'h00); issue(1, 1, 9'h1FF, 8'hB2); end
        join
        settle();
        // slave error then a normal transfer
        err_cfg = 1;
        grant_q.push_back(0);
        bus_q.push_back('{1, 0, 0, 9'h00E, 8'h00, 1, -1});
        rsp_q.push_back('{0, 1, 8'h44, 1});
        issue(0, 0, 9'h00E, 8'h00);
        settle();
        err_cfg = 0;
        grant_q.push_back(1);
        bus_q.push_back('{1, 0, 0, 9'h001, 8'h00, 1, -1});
        rsp_q.push_back('{1, 1, 8'h44, 0});
        issue(1, 0, 9'h001, 8'h00);
        settle();
        // reset while in ACCESS: transfer dropped, no response
        waits_cfg = 6;
        grant_q.push_back(0);
        issue(0, 0, 9'h002, 8'h00);
        for (int t = 0; t < 50 && !PENABLE; t++) @(negedge PCLK);
        chk("penable_before_reset", PENABLE, 1);
        PRESET = 1;
        @(negedge PCLK);
        chk("midreset_outputs", all_outs(), 0);
        PRESET = 0;
        waits_cfg = 0;
        repeat (2) @(negedge PCLK);
        // first tie after reset goes to requester 0
        grant_q.push_back(0); grant_q.push_back(1);
        bus_q.push_back('{1, 0, 0, 9'h004, 8'h00, 1, -1});
        bus_q.push_back('{0, 1, 0, 9'h104, 8'h00, 1, 0});
        rsp_q.push_back('{0, 1, 8'h44, 0});
        rsp_q.push_back('{1, 1, 8'h55, 0});
        fork
            issue(0, 0, 9'h004, 8'h00);
            issue(1, 0, 9'h104, 8'h00);
        join
        settle();
        chk("grant_q_drained", grant_q.size(), 0);
        chk("bus_q_drained", bus_q.size(), 0);
        chk("rsp_q_drained", rsp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
